au_reduce: RTL

Sequential reduction engine for the arithmetic unit's three-function command set (subtract, add, max). A start command selects the function and a word count. The block accepts that many signed words over a valid/ready input stream and folds them into one accumulator. It then presents the result, with a sticky overflow flag, on a valid/ready output stream. The block sits on the datapath side of the AU and issues the operand-pair sequence that the combinational unit only answers one pair at a time.

---
 rtl/au_reduce.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/au_reduce.sv
// au_reduce -- sequential reduction engine for the AU command set.
//
// A start command picks a function (subtract, add, max) and a word count.
// The block then accepts that many signed words on a valid/ready input
// stream and folds them into one accumulator. The result is offered,
// together with a sticky signed-overflow flag, on a valid/ready output
// stream.
//
// Parameters
//   MSB        data MSB; word width is MSB+1
//   LW         width of the length field (max count 2^LW-1)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   start      command strobe, only looked at in IDLE
//   fun        function: 00 subtract, 01 add, 1x max
//   len        number of words to reduce (0 gives an immediate zero result)
//   in_data    input word, two's complement
//   in_valid   in_data is valid
//   in_ready   block takes in_data this cycle (high throughout RUN)
//   out_data   reduction result (valid in DONE, zero otherwise)
//   out_ovf    sticky signed overflow for add/subtract
//   out_valid  result is valid (high throughout DONE)
//   out_ready  consumer takes the result
//   busy       high in RUN and DONE
module au_reduce #(
  parameter int MSB = 15,
  parameter int LW  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    fun,
  input  logic [LW-1:0] len,
  input  logic [MSB:0]  in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [MSB:0]  out_data,
  output logic          out_ovf,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        next_state;

  logic [MSB:0]  acc;
  logic [LW-1:0] cnt;
  logic [LW-1:0] cnt_inc;
  logic [LW-1:0] len_q;
  logic [1:0]    fun_q;
  logic          ovf;
  logic          accept;

  logic [MSB:0]  sum_sub;
  logic [MSB:0]  sum_add;
  logic          ovf_sub;
  logic          ovf_add;

  // State register. Reset always lands in IDLE, abandoning any reduction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake outputs. in_ready/out_valid depend on state
  // only, so neither stream sees a combinational path through the block.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    cnt_inc    = cnt + 1'b1;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = (len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        accept   = in_valid;
        if (accept && (cnt_inc == len_q)) begin
          next_state = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Candidate results for the next fold. Subtract is built as acc + ~x + 1
  // so it matches the AU bit-for-bit; max reuses the subtract difference
  // and looks only at its sign bit (wrap-around compare, no correction).
  always_comb begin
    sum_sub = acc + ~in_data + 1'b1;
    sum_add = acc + in_data;
    ovf_sub = (acc[MSB] != in_data[MSB]) && (sum_sub[MSB] != acc[MSB]);
    ovf_add = (acc[MSB] == in_data[MSB]) && (sum_add[MSB] != acc[MSB]);
  end

  // Datapath: command latch, word counter, accumulator and sticky ovf.
  // The first word of a command only loads acc, so it can never overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
      len_q <= '0;
      fun_q <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ovf <= 1'b0;
            cnt <= '0;
            if (len == '0) begin
              acc <= '0;
            end else begin
              fun_q <= fun;
              len_q <= len;
            end
          end
        end
        RUN: begin
          if (accept) begin
            cnt <= cnt_inc;
            if (cnt == '0) begin
              acc <= in_data;
            end else begin
              case (fun_q)
                2'b00: begin
                  acc <= sum_sub;
                  if (ovf_sub) ovf <= 1'b1;
                end
                2'b01: begin
                  acc <= sum_add;
                  if (ovf_add) ovf <= 1'b1;
                end
                default: begin
                  if (sum_sub[MSB]) acc <= in_data;
                end
              endcase
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // The result is only presented while DONE; elsewhere the port reads zero.
  always_comb begin
    out_data = '0;
    out_ovf  = 1'b0;
    if (state == DONE) begin
      out_data = acc;
      out_ovf  = ovf;
    end
  end

endmodule
